system_buttons_pio_in: RTL and testbench
========================================

// Module: system_buttons_pio_in
// PURPOSE
//  Avalon-MM slave input PIO: the read-side counterpart of the 8-bit output PIO.
//  - Samples an external WIDTH-bit input bus (push-buttons/switches) through a 2-flop synchronizer.
//  - Filter stage: debounce when enabled, pass-through otherwise.
//  - Latches per-bit edge events in a write-1-to-clear register; raises a maskable level IRQ to the CPU.
// PARAMETERS
//  WIDTH            8      input bus width, 1..32
//  EDGE_TYPE        1      edge capture select: 0 rising, 1 falling, 2 any
//  DEBOUNCE_CYCLES  50000  stable cycles required before a filtered bit changes (>=2)
// PORTS
//  clk         in   1      system clock; the only clock
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   2      register word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, zero-extended
//  in_port     in   WIDTH  asynchronous external inputs
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  Reset: all state flops 0; readdata 0; irq 0. Reset asserted mid-operation clears pending edges and counters immediately.
//  Sync: s1 <= in_port; s2 <= s1. Bits are filtered to f, then f_d <= f.
//  Register map (unused readdata bits are 0):
//   0 DATA    RO   f
//   1 -       RO   0; writes ignored
//   2 IRQMASK RW   mask[WIDTH-1:0], reset 0
//   3 EDGECAP W1C  edge[WIDTH-1:0]; written 1 bits clear, 0 bits keep
//  Write: occurs on the clk edge where chipselect && !write_n. Writes to addr 0 and 1 are ignored.
//  Read: readdata is combinational from address; zero wait states; no read side effects.
//  Edge detect: rise = f & ~f_d; fall = ~f & f_d; ev = rise, fall or both per EDGE_TYPE.
//   edge[i] <= ev[i] | (edge[i] & ~clr[i]).
//   Simultaneous event and clear on the same bit: the set wins, so no event is lost.
//  irq = |(edge & mask), registered; asserts 1 clk after edge/mask update, deasserts 1 clk after clear.
//  Latency: in_port change to DATA is 2 clk (sync) + 1 clk (filter reg); edge bit sets 1 clk later.
//  Unpressed input is 1: f resets to 0, then DATA follows input after sync.
//   The reset-release 0->1 transition is a rising edge; software clears EDGECAP after init.
// CONFIGURATION
//  Macro SYSTEM_PIO_IN_DEBOUNCE_EN:
//   Defined: each bit has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
//    s2 != f: counter increments; s2 == f: counter resets to 0.
//    On counter == DEBOUNCE_CYCLES-1 with s2 != f: f <= s2 and counter <= 0.
//    Glitches shorter than DEBOUNCE_CYCLES clk never reach f.
//    The counter saturates, never wraps.
//   Undefined: f <= s2 (one register stage); DEBOUNCE_CYCLES ignored; no counters synthesized.
// STRUCTURE
//  Package system_pio_pkg: register address constants (PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2,
//   PIO_ADDR_EDGECAP=3) and EDGE_TYPE encodings (EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2).
//  Sub-module pio_in_debounce: one bit of sync + filter + counter, instantiated WIDTH times in a generate loop.
//   Output f, reset 0.
//  Top level holds edge detect, mask/edge regs, read mux and irq.
// TESTING
//  Bench overrides: DEBOUNCE_CYCLES=4, EDGE_TYPE=1 unless stated.
//  1 Reset: hold reset_n=0 with in_port=8'hFF -> readdata=0, irq=0; release -> DATA reads 8'hFF within 3 clk (7 with debounce).
//  2 Falling edge + IRQ:
//     write IRQMASK=8'h01, EDGECAP=8'hFF; drop in_port[0] -> EDGECAP reads 8'h01, irq=1;
//     write EDGECAP=8'h01 -> irq=0 next clk.
//  3 Mask: mask=0, fall on bit 3 -> EDGECAP=8'h08, irq stays 0; then write mask=8'h08 -> irq=1 one clk later.
//  4 Set/clear collision: schedule the EDGECAP clear write on the same clk as bit 2 edge-set -> EDGECAP bit 2 reads 1.
//  5 Debounce (macro defined):
//     3-clk low glitch on bit 1 -> DATA and EDGECAP unchanged;
//     6-clk low pulse -> DATA bit1=0 and EDGECAP bit1=1.
//  6 EDGE_TYPE=2, macro undefined: toggle bit 5 up then down -> edge sets each time; DATA tracks 3 clk after in_port.
//     Address 1 reads 0; writes to addr 0 and 1 have no effect.

Source files
------------

// File: rtl/system_pio_pkg.sv
// Register map and edge-select constants for the input PIO.
package system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: 2-flop synchronizer plus filter register.
// SYSTEM_PIO_IN_DEBOUNCE_EN adds a per-bit stability counter.
import system_pio_pkg::*;

module pio_in_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_f
);

  logic r_s1;
  logic r_s2;
  logic r_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

`ifdef SYSTEM_PIO_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Count cycles of disagreement; any agreement restarts the wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_f   <= 1'b0;
    end else if (r_s2 == r_f) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_f   <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  localparam int unused_dc = DEBOUNCE_CYCLES;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_f <= 1'b0;
    else          r_f <= r_s2;
  end
`endif

  assign o_f = r_f;

endmodule

// File: rtl/system_buttons_pio_in.sv
// Avalon-MM input PIO: filtered DATA, W1C edge capture, masked IRQ.
// Debounce filter enabled by SYSTEM_PIO_IN_DEBOUNCE_EN.
import system_pio_pkg::*;

module system_buttons_pio_in #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam bit RISE_EN = (EDGE_TYPE != EDGE_FALL);
  localparam bit FALL_EN = (EDGE_TYPE != EDGE_RISE);

  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_ev;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_fd;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic             r_irq;
  logic             w_wr;
  logic             w_unused;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    pio_in_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .reset_n(reset_n),
      .i_d    (in_port[gi]),
      .o_f    (w_f[gi])
    );
  end

  assign w_wr  = chipselect & ~write_n;
  assign w_clr = (w_wr && address == PIO_ADDR_EDGECAP)
               ? writedata[WIDTH-1:0] : '0;

  assign w_ev = ({WIDTH{RISE_EN}} & w_f & ~r_fd)
              | ({WIDTH{FALL_EN}} & ~w_f & r_fd);

  // A new event outranks a same-cycle clear so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fd   <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_fd   <= w_f;
      r_edge <= w_ev | (r_edge & ~w_clr);
      r_irq  <= |(r_edge & r_mask);
      if (w_wr && address == PIO_ADDR_IRQMASK)
        r_mask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = w_f;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = r_mask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edge;
      default:          readdata = '0;
    endcase
  end

  assign irq      = r_irq;
  assign w_unused = ^writedata;

endmodule

// File: tb/tb_system_buttons_pio_in.sv
// Bench for system_buttons_pio_in: directed table, corner sequences,
// random traffic against a cycle-history reference model.
module tb_system_buttons_pio_in;

  localparam int DC = 4;
  localparam int HN = DC + 2;
`ifdef SYSTEM_PIO_IN_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT      = DEB ? 7 : 3;
  localparam int SET_EDGE = DEB ? DC + 2 : 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata1, readdata2;
  logic        irq1, irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  system_buttons_pio_in #(
    .WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DC)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata1),
    .in_port(in_port), .irq(irq1)
  );

  system_buttons_pio_in #(
    .WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DC)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata2),
    .in_port(in_port), .irq(irq2)
  );

  typedef struct {
    logic [7:0]  in;
    logic        wr;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic [1:0]  ra;
    logic [31:0] rd;
    logic        irq;
  } vec_t;

  vec_t tv[10];

  // Reference model: h[k] is in_port as sampled k edges ago.
  logic [7:0] h[HN];
  logic [7:0] mf, mfd, mmask;
  logic [7:0] medge[2];
  logic       mirq[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = {24'h0, d};
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string nm, input int j,
                    input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(nm, (j == 0) ? readdata1 : readdata2, exp);
  endtask

  function automatic logic [31:0] exp_rd(input int j,
                                         input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, mf};
      2'd2:    return {24'h0, mmask};
      2'd3:    return {24'h0, medge[j]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < HN; k++) h[k] = 8'h0;
    mf = 0; mfd = 0; mmask = 0;
    medge[0] = 0; medge[1] = 0;
    mirq[0] = 0; mirq[1] = 0;
  endtask

  // Advance the model across one rising edge using current inputs.
  task automatic model_step();
    logic [7:0] nf, rise, fall, clr;
    logic [7:0] ev[2];
    bit flip;
    for (int k = HN - 1; k > 0; k--) h[k] = h[k-1];
    h[0] = in_port;
    if (DEB) begin
      for (int i = 0; i < 8; i++) begin
        flip = 1'b1;
        for (int k = 2; k <= DC + 1; k++)
          if (h[k][i] == mf[i]) flip = 1'b0;
        nf[i] = flip ? ~mf[i] : mf[i];
      end
    end else begin
      nf = h[2];
    end
    rise  = mf & ~mfd;
    fall  = ~mf & mfd;
    ev[0] = fall;
    ev[1] = rise | fall;
    clr = (chipselect && !write_n && address == 2'd3)
        ? writedata[7:0] : 8'h0;
    for (int j = 0; j < 2; j++) begin
      mirq[j]  = |(medge[j] & mmask);
      medge[j] = ev[j] | (medge[j] & ~clr);
    end
    if (chipselect && !write_n && address == 2'd2)
      mmask = writedata[7:0];
    mfd = mf;
    mf  = nf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{8'hFF, 1'b1, 2'd2, 8'h01, 2'd2, 32'h01, 1'b0};
    tv[1] = '{8'hFE, 1'b0, 2'd0, 8'h00, 2'd3, 32'h01, 1'b1};
    tv[2] = '{8'hFE, 1'b0, 2'd0, 8'h00, 2'd0, 32'hFE, 1'b1};
    tv[3] = '{8'hFE, 1'b1, 2'd3, 8'h01, 2'd3, 32'h00, 1'b0};
    tv[4] = '{8'hFE, 1'b1, 2'd2, 8'h00, 2'd2, 32'h00, 1'b0};
    tv[5] = '{8'hF6, 1'b0, 2'd0, 8'h00, 2'd3, 32'h08, 1'b0};
    tv[6] = '{8'hFF, 1'b0, 2'd0, 8'h00, 2'd3, 32'h08, 1'b0};
    tv[7] = '{8'hFF, 1'b1, 2'd0, 8'hFF, 2'd2, 32'h00, 1'b0};
    tv[8] = '{8'hFF, 1'b1, 2'd1, 8'hFF, 2'd3, 32'h08, 1'b0};
    tv[9] = '{8'hFF, 1'b0, 2'd0, 8'h00, 2'd1, 32'h00, 1'b0};

    reset_n    = 1'b0;
    in_port    = 8'hFF;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;

    repeat (3) @(negedge clk);
    rd("rst_data_a", 0, 2'd0, 32'h0);
    rd("rst_data_b", 1, 2'd0, 32'h0);
    rd("rst_edge_a", 0, 2'd3, 32'h0);
    chk("rst_irq_a", 32'(irq1), 32'h0);

    reset_n = 1'b1;
    address = 2'd0;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      #1;
      if (readdata1 == 32'hFF) break;
    end
    chk("rst_release_data", readdata1, 32'hFF);

    repeat (4) @(negedge clk);
    wr(2'd3, 8'hFF);
    rd("init_edge_a", 0, 2'd3, 32'h0);
    rd("init_edge_b", 1, 2'd3, 32'h0);

    for (int r = 0; r < 10; r++) begin
      in_port = tv[r].in;
      if (tv[r].wr) wr(tv[r].wa, tv[r].wd);
      else          @(negedge clk);
      repeat (8) @(negedge clk);
      address = tv[r].ra;
      #1;
      chk($sformatf("vec%0d_rd", r), readdata1, tv[r].rd);
      chk($sformatf("vec%0d_irq", r), 32'(irq1), 32'(tv[r].irq));
    end

    wr(2'd2, 8'h08);
    chk("mask_irq_early", 32'(irq1), 32'h0);
    @(negedge clk);
    chk("mask_irq_late", 32'(irq1), 32'h1);
    wr(2'd3, 8'h08);
    @(negedge clk);
    chk("clr_irq", 32'(irq1), 32'h0);

    in_port = 8'hFB;
    repeat (SET_EDGE) @(negedge clk);
    wr(2'd3, 8'hFF);
    rd("collision_edge", 0, 2'd3, 32'h04);

`ifdef SYSTEM_PIO_IN_DEBOUNCE_EN
    wr(2'd3, 8'hFF);
    in_port = 8'hF9;
    repeat (3) @(negedge clk);
    in_port = 8'hFB;
    repeat (10) @(negedge clk);
    rd("glitch_data", 0, 2'd0, 32'hFB);
    rd("glitch_edge", 0, 2'd3, 32'h00);
    in_port = 8'hF9;
    repeat (6) @(negedge clk);
    rd("pulse_data_low", 0, 2'd0, 32'hF9);
    in_port = 8'hFB;
    repeat (10) @(negedge clk);
    rd("pulse_edge", 0, 2'd3, 32'h02);
    rd("pulse_data_back", 0, 2'd0, 32'hFB);
`else
    in_port = 8'hDB;
    repeat (6) @(negedge clk);
    wr(2'd3, 8'hFF);
    in_port = 8'hFB;
    repeat (2) @(negedge clk);
    rd("any_data_2clk", 1, 2'd0, 32'hDB);
    @(negedge clk);
    rd("any_data_3clk", 1, 2'd0, 32'hFB);
    @(negedge clk);
    rd("any_rise_edge", 1, 2'd3, 32'h20);
    wr(2'd3, 8'hFF);
    in_port = 8'hDB;
    repeat (4) @(negedge clk);
    rd("any_fall_edge", 1, 2'd3, 32'h20);
    rd("fall_edge_a", 0, 2'd3, 32'h20);
    rd("any_addr1", 1, 2'd1, 32'h0);
`endif

    #2;
    reset_n = 1'b0;
    #1;
    rd("midrst_edge_a", 0, 2'd3, 32'h0);
    rd("midrst_edge_b", 1, 2'd3, 32'h0);
    rd("midrst_mask", 0, 2'd2, 32'h0);
    chk("midrst_irq", 32'(irq1), 32'h0);

    repeat (2) @(negedge clk);
    in_port = 8'hFF;
    reset_n = 1'b1;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(4) == 0) in_port = in_port ^ 8'($urandom);
      chipselect = ($urandom_range(1) == 1);
      write_n    = ($urandom_range(2) != 0);
      address    = 2'($urandom);
      writedata  = $urandom;
      model_step();
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'($urandom);
      #1;
      chk("rnd_rd_a", readdata1, exp_rd(0, address));
      chk("rnd_rd_b", readdata2, exp_rd(1, address));
      chk("rnd_irq_a", 32'(irq1), 32'(mirq[0]));
      chk("rnd_irq_b", 32'(irq2), 32'(mirq[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
